const_load_seq: RTL and testbench
=================================

CONST_LOAD_SEQ -- requirements
Module: const_load_seq

Interface
REQ-001 Parameter RD_W, default 5: destination register index width.
REQ-002 clk  input  1  rising-edge clock; all state changes on it.
REQ-003 reset_n  input  1  reset, synchronous and active-low, sampled on the rising edge of clk.
REQ-004 req_valid  input  1  a 64-bit constant load request is present.
REQ-005 req_ready  output  1  block can accept a request.
REQ-006 req_imm  input  64  constant to build in the destination register.
REQ-007 req_rd  input  RD_W  destination register index.
REQ-008 mov_valid  output  1  a wide-move op is being issued this cycle.
REQ-009 mov_stall  input  1  pipeline cannot take the op this cycle.
REQ-010 mov_type  output  1  mov datapath select: 0 = MOVK (keep), 1 = MOVZ (zero).
REQ-011 mov_shamt  output  2  halfword slot: 0..3 selects bits [15:0], [31:16], [47:32], [63:48].
REQ-012 mov_imm16  output  16  halfword value for the selected slot.
REQ-013 mov_rd  output  RD_W  latched destination index.
REQ-014 busy  output  1  high whenever the FSM is not IDLE.
REQ-015 done  output  1  one-cycle pulse after the last op of a request is consumed.

Function
REQ-016 FSM states: IDLE, ISSUE, FIN; any unused encoding returns to IDLE on the next edge.
REQ-017 req_ready is high only in IDLE.
REQ-018 Accept happens on any edge where req_valid and req_ready are both high; at accept, latch req_imm, req_rd and the 4-bit halfword issue mask, then go to ISSUE.
REQ-019 req_imm and req_rd are ignored in every cycle except the accept edge.
REQ-020 In ISSUE, mov_valid is high. Ops issue in ascending slot order from the issue mask.
  - First op: mov_type=1 (MOVZ).
  - Every later op: mov_type=0 (MOVK).
REQ-021 mov_imm16 equals the latched bits [16*s+15 : 16*s], where s = mov_shamt.
REQ-022 An op is consumed on an edge where mov_valid is high and mov_stall is low; the block then advances to the next masked slot.
REQ-023 While mov_stall is high, mov_valid, mov_type, mov_shamt, mov_imm16 and mov_rd hold stable and nothing advances.
REQ-024 Consuming the final masked op moves the FSM to FIN. done is high for the single FIN cycle, then the FSM returns to IDLE.
REQ-025 Latency with no stalls, accept at edge N:
  - First mov_valid in cycle N+1.
  - k ops occupy cycles N+1..N+k.
  - done in cycle N+k+1.
  - req_ready high again in cycle N+k+2.
REQ-026 An empty mask (only possible when req_imm = 0 under REQ-032) is forced to slot 0. Exactly one op is issued: MOVZ, shamt 0, imm16 0.
REQ-027 When mov_valid is low, mov_type, mov_shamt, mov_imm16 and mov_rd are driven to 0.
REQ-028 The op counter saturates at 4 ops per request and never wraps into a new request.

Reset
REQ-029 reset_n low at a clock edge forces the following, regardless of state:
  - FSM to IDLE.
  - Latched immediate, rd and mask to 0.
  - mov_valid, busy and done to 0.
  - req_ready to 1 in the first cycle after reset_n rises.
REQ-030 Reset during ISSUE abandons the request. No further ops and no done pulse are emitted for it.
REQ-031 req_valid sampled while reset_n is low is not accepted.

Configuration
REQ-032 With macro CONST_LOAD_SKIP_ZERO_EN defined, the issue mask has bit s set only when halfword s of req_imm is nonzero. Zero halfwords are skipped, and the first nonzero slot is issued as MOVZ.
REQ-033 With CONST_LOAD_SKIP_ZERO_EN undefined, the mask is always 4'b1111. Every request issues exactly four ops: MOVZ slot 0, then MOVK slots 1, 2, 3.

Verification
REQ-034 Macro on, imm=0x0000_0000_0000_1234, rd=3, no stall:
  - Cycle N+1: one op, MOVZ, shamt 0, imm16 0x1234, rd 3.
  - done in cycle N+2.
REQ-035 Macro on, imm=0xDEAD_0000_BEEF_0000:
  - MOVZ, shamt 1, imm16 0xBEEF.
  - Then MOVK, shamt 3, imm16 0xDEAD.
  - done one cycle after.
REQ-036 Macro on, imm=0:
  - Single MOVZ, shamt 0, imm16 0x0000.
  - Macro off, imm=0x1: four ops with imm16 0x0001, 0, 0, 0 at shamt 0..3.
REQ-037 mov_stall high for 3 cycles while the second op of 0x1111_2222_3333_4444 (macro off) is presented:
  - Op stays MOVK, shamt 1, imm16 0x3333 for 4 cycles total.
  - done is delayed by exactly 3 cycles.
REQ-038 reset_n low for one edge while the third op is presented:
  - Next cycle: mov_valid=0, busy=0, done never pulses.
  - req_ready=1 after reset_n rises.
  - A new request is then accepted normally.

Source files
------------

// File: rtl/const_load_seq.sv
// const_load_seq: expands one 64-bit constant load request into a short
// sequence of wide-move ops (MOVZ for the first slot, MOVK for the rest),
// one 16-bit halfword per op, in ascending slot order.
//
// Handshakes:
//   req:  a request is taken on any rising edge where req_valid and req_ready
//         are both high. req_ready is high only while idle.
//   mov:  an op is consumed on any rising edge where mov_valid is high and
//         mov_stall is low. While it is stalled, every mov_* output holds.
//
// Optional feature: define CONST_LOAD_SKIP_ZERO_EN to skip zero halfwords.
// Without it, every request issues all four slots.
// The FSM state is exposed on fsm_state for observation.
module const_load_seq #(
   parameter int RD_W = 5
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [63:0]     req_imm,
   input  logic [RD_W-1:0] req_rd,
   output logic            mov_valid,
   input  logic            mov_stall,
   output logic            mov_type,
   output logic [1:0]      mov_shamt,
   output logic [15:0]     mov_imm16,
   output logic [RD_W-1:0] mov_rd,
   output logic            busy,
   output logic            done,
   output logic [1:0]      fsm_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      FIN   = 2'd2
   } state_t;

   state_t          state;
   logic [63:0]     imm_q;
   logic [RD_W-1:0] rd_q;
   logic [3:0]      mask_q;    // slots still to issue after the current op
   logic [2:0]      op_cnt;    // ops issued for this request, stops at 4
   logic [3:0]      req_mask;
   logic [1:0]      acc_slot;
   logic [1:0]      nxt_slot;

   // Lowest set slot of a mask. An all-zero mask never reaches this.
   function automatic logic [1:0] low_slot(input logic [3:0] m);
      if (m[0])      return 2'd0;
      else if (m[1]) return 2'd1;
      else if (m[2]) return 2'd2;
      else           return 2'd3;
   endfunction

   // Halfword s of a 64-bit value.
   function automatic logic [15:0] halfword(input logic [63:0] v, input logic [1:0] s);
      logic [63:0] t;
      t = v >> {s, 4'h0};
      return t[15:0];
   endfunction

   // Issue mask derived from the incoming immediate. An empty mask falls back
   // to slot 0 so that a zero constant still gets its single MOVZ.
   always_comb begin
      req_mask = 4'b0000;
`ifdef CONST_LOAD_SKIP_ZERO_EN
      for (int s = 0; s < 4; s++) begin
         req_mask[s] = |req_imm[16*s +: 16];
      end
      if (req_mask == 4'b0000) begin
         req_mask = 4'b0001;
      end
`else
      req_mask = 4'b1111;
`endif
   end

   // Slot of the first op at accept and of the next op while issuing.
   always_comb begin
      acc_slot = low_slot(req_mask);
      nxt_slot = low_slot(mask_q);
   end

   // Sequencer FSM with registered op outputs.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= IDLE;
         imm_q     <= '0;
         rd_q      <= '0;
         mask_q    <= '0;
         op_cnt    <= '0;
         mov_valid <= 1'b0;
         mov_type  <= 1'b0;
         mov_shamt <= '0;
         mov_imm16 <= '0;
         mov_rd    <= '0;
         done      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (req_valid) begin
                  imm_q     <= req_imm;
                  rd_q      <= req_rd;
                  mask_q    <= req_mask & ~(4'b0001 << acc_slot);
                  op_cnt    <= 3'd1;
                  mov_valid <= 1'b1;
                  mov_type  <= 1'b1;
                  mov_shamt <= acc_slot;
                  mov_imm16 <= halfword(req_imm, acc_slot);
                  mov_rd    <= req_rd;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               if (!mov_stall) begin
                  if (mask_q == 4'b0000 || op_cnt == 3'd4) begin
                     // Last op consumed: drop the op and pulse done.
                     mask_q    <= '0;
                     mov_valid <= 1'b0;
                     mov_type  <= 1'b0;
                     mov_shamt <= '0;
                     mov_imm16 <= '0;
                     mov_rd    <= '0;
                     done      <= 1'b1;
                     state     <= FIN;
                  end else begin
                     mask_q    <= mask_q & ~(4'b0001 << nxt_slot);
                     op_cnt    <= op_cnt + 3'd1;
                     mov_type  <= 1'b0;
                     mov_shamt <= nxt_slot;
                     mov_imm16 <= halfword(imm_q, nxt_slot);
                     mov_rd    <= rd_q;
                  end
               end
            end
            FIN: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               mov_valid <= 1'b0;
               mov_type  <= 1'b0;
               mov_shamt <= '0;
               mov_imm16 <= '0;
               mov_rd    <= '0;
               done      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

   assign req_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign fsm_state = state;

endmodule

// File: tb/tb_const_load_seq.sv
// Testbench for const_load_seq: directed table of requests plus randomized
// requests, each checked op by op against a reference model built from the
// slot rules (which halfwords issue, MOVZ first, ascending order, timing).
module tb_const_load_seq;

   localparam int RD_W = 5;

   logic            clk;
   logic            reset_n;
   logic            req_valid;
   logic            req_ready;
   logic [63:0]     req_imm;
   logic [RD_W-1:0] req_rd;
   logic            mov_valid;
   logic            mov_stall;
   logic            mov_type;
   logic [1:0]      mov_shamt;
   logic [15:0]     mov_imm16;
   logic [RD_W-1:0] mov_rd;
   logic            busy;
   logic            done;
   logic [1:0]      fsm_state;

   int tests = 0;
   int fails = 0;

   const_load_seq #(.RD_W(RD_W)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_imm   (req_imm),
      .req_rd    (req_rd),
      .mov_valid (mov_valid),
      .mov_stall (mov_stall),
      .mov_type  (mov_type),
      .mov_shamt (mov_shamt),
      .mov_imm16 (mov_imm16),
      .mov_rd    (mov_rd),
      .busy      (busy),
      .done      (done),
      .fsm_state (fsm_state)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        typ;
      logic [1:0]  sh;
      logic [15:0] v;
   } op_t;

   typedef struct {
      logic [63:0]     imm;
      logic [RD_W-1:0] rd;
      int              stall_op;
      int              stall_len;
      int              exp_k;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: list of ops a request must produce.
   task automatic model_ops(input logic [63:0] imm, output op_t ops[$]);
      bit   take[4];
      bit   any;
      op_t  o;
      ops = {};
      any = 0;
      for (int s = 0; s < 4; s++) begin
`ifdef CONST_LOAD_SKIP_ZERO_EN
         take[s] = (((imm >> (16 * s)) & 64'hFFFF) != 0);
`else
         take[s] = 1;
`endif
         if (take[s]) any = 1;
      end
      if (!any) take[0] = 1;
      for (int s = 0; s < 4; s++) begin
         if (take[s]) begin
            o.typ = (ops.size() == 0);
            o.sh  = 2'(s);
            o.v   = 16'((imm >> (16 * s)) & 64'hFFFF);
            ops.push_back(o);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int cyc;
      cyc = 0;
      while (!req_ready && cyc < 50) begin
         tick();
         cyc++;
      end
      check("req_ready_wait", req_ready, 1);
   endtask

   // Drive one request and follow it to completion.
   task automatic run_req(input logic [63:0] imm, input logic [RD_W-1:0] rd,
                          input int stall_op, input int stall_len,
                          input int stall_pct, input int exp_k);
      op_t q[$];
      int  idx, stalled, lat, total_stall, k;
      bit  st;
      model_ops(imm, q);
      k = q.size();
      if (exp_k >= 0) check("op_count_model", k, exp_k);
      wait_ready();
      req_valid = 1'b1;
      req_imm   = imm;
      req_rd    = rd;
      tick();
      req_valid = 1'b0;
      req_imm   = {$urandom, $urandom};
      req_rd    = RD_W'($urandom);
      idx = 0; stalled = 0; lat = 1; total_stall = 0;
      while (q.size() > 0 && lat < 200) begin
         check("mov_valid", mov_valid, 1);
         check("mov_type",  mov_type,  q[0].typ);
         check("mov_shamt", mov_shamt, q[0].sh);
         check("mov_imm16", mov_imm16, q[0].v);
         check("mov_rd",    mov_rd,    rd);
         check("busy_issue", busy, 1);
         check("done_issue", done, 0);
         check("ready_issue", req_ready, 0);
         st = 0;
         if (idx == stall_op && stalled < stall_len) begin
            st = 1;
            stalled++;
         end else if (stall_pct > 0 && $urandom_range(99) < stall_pct) begin
            st = 1;
         end
         if (st) total_stall++;
         mov_stall = st;
         tick();
         lat++;
         if (!st) begin
            void'(q.pop_front());
            idx++;
         end
      end
      mov_stall = 1'b0;
      check("ops_timeout", q.size(), 0);
      check("done_pulse", done, 1);
      check("mov_valid_fin", mov_valid, 0);
      check("mov_fields_fin", {mov_type, mov_shamt, mov_imm16, mov_rd}, 0);
      check("busy_fin", busy, 1);
      check("ready_fin", req_ready, 0);
      check("done_latency", lat, k + total_stall + 1);
      tick();
      check("done_clear", done, 0);
      check("ready_back", req_ready, 1);
      check("busy_clear", busy, 0);
   endtask

   vec_t vecs[7];

   initial begin
`ifdef CONST_LOAD_SKIP_ZERO_EN
      vecs[0] = '{64'h0000_0000_0000_1234, 5'd3,  -1, 0, 1};
      vecs[1] = '{64'hDEAD_0000_BEEF_0000, 5'd7,  -1, 0, 2};
      vecs[2] = '{64'h0000_0000_0000_0000, 5'd1,  -1, 0, 1};
      vecs[3] = '{64'h0000_0000_0000_0001, 5'd9,  -1, 0, 1};
      vecs[4] = '{64'h1111_2222_3333_4444, 5'd12,  1, 3, 4};
      vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 5'd31, -1, 0, 4};
      vecs[6] = '{64'h0000_FFFF_0000_0000, 5'd0,   0, 2, 1};
`else
      vecs[0] = '{64'h0000_0000_0000_1234, 5'd3,  -1, 0, 4};
      vecs[1] = '{64'hDEAD_0000_BEEF_0000, 5'd7,  -1, 0, 4};
      vecs[2] = '{64'h0000_0000_0000_0000, 5'd1,  -1, 0, 4};
      vecs[3] = '{64'h0000_0000_0000_0001, 5'd9,  -1, 0, 4};
      vecs[4] = '{64'h1111_2222_3333_4444, 5'd12,  1, 3, 4};
      vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 5'd31, -1, 0, 4};
      vecs[6] = '{64'h0000_FFFF_0000_0000, 5'd0,   0, 2, 4};
`endif
      reset_n   = 1'b0;
      req_valid = 1'b1;
      req_imm   = 64'h1234_5678_9ABC_DEF0;
      req_rd    = 5'd4;
      mov_stall = 1'b0;

      // reset with req_valid held high: must not be accepted
      repeat (3) tick();
      check("rst_mov_valid", mov_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      reset_n   = 1'b1;
      req_valid = 1'b0;
      check("rst_ready", req_ready, 1);
      tick();
      check("post_rst_busy", busy, 0);
      check("post_rst_ready", req_ready, 1);

      // directed table
      for (int i = 0; i < 7; i++) begin
         run_req(vecs[i].imm, vecs[i].rd, vecs[i].stall_op, vecs[i].stall_len, 0, vecs[i].exp_k);
      end

      // reset while the third op is presented
      wait_ready();
      req_valid = 1'b1;
      req_imm   = 64'h1111_2222_3333_4444;
      req_rd    = 5'd6;
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      check("third_op_valid", mov_valid, 1);
      check("third_op_shamt", mov_shamt, 2);
      check("third_op_imm16", mov_imm16, 16'h2222);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      check("abort_mov_valid", mov_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_ready", req_ready, 1);
      for (int i = 0; i < 6; i++) begin
         check("abort_no_done", done, 0);
         check("abort_no_op", mov_valid, 0);
         tick();
      end
      run_req(64'hCAFE_0000_0000_BABE, 5'd21, -1, 0, 0, -1);

      // randomized requests with random stalls
      for (int i = 0; i < 40; i++) begin
         logic [63:0] imm;
         for (int s = 0; s < 4; s++) begin
            imm[16*s +: 16] = ($urandom_range(1) == 1) ? 16'($urandom) : 16'h0000;
         end
         run_req(imm, RD_W'($urandom), -1, 0, 30, -1);
         repeat ($urandom_range(2)) tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
